// File: rtl/scc_mem_arbiter.sv
// scc_mem_arbiter
//   Memory front-end for the SCC core. Arbitrates the instruction-fetch and
//   data-access requesters onto one unified single-port synchronous memory,
//   with configurable wait states, valid/grant handshakes, halt-aware fetch
//   gating and sticky misalignment error bits.
//
//   Build option: define SCC_ARB_RR_EN for round-robin arbitration on
//   contention (last-served register resets to "fetch"); otherwise data has
//   fixed priority over fetch.
//
// Ports
//   clk, rst               rising-edge clock, asynchronous active-low reset
//   clk_en                 global advance enable (low freezes all state)
//   halt                   core halted, blocks new fetch grants
//   i_req/i_addr           fetch request and byte address
//   i_gnt/i_valid/i_rdata  fetch grant, response strobe, fetched word
//   d_req/d_we/d_addr/d_wdata  data request, write flag, address, write data
//   d_gnt/d_valid/d_rdata  data grant, response strobe, read data (0 on write)
//   mem_addr/mem_re/mem_we/mem_wdata/mem_rdata  unified memory interface
//   busy                   FSM is not idle
//   err_bits               sticky misalignment: [0] fetch, [1] data
module scc_mem_arbiter #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              halt,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        err_bits
);

  localparam int unsigned       LSB_W      = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << LSB_W) - 64'd1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              we_q;
  logic              src_d_q;
  logic              mis_q;
  logic [1:0]        err_q;

  logic              i_ok;
  logic              pick_d;
  logic              gnt_i;
  logic              gnt_d;
  logic              mem_done;
  logic              strobe;
  logic [ADDR_W-1:0] sel_addr;

  assign i_ok = i_req & ~halt;

`ifdef SCC_ARB_RR_EN
  // 1 = data channel was served last; on contention the other one wins.
  logic last_d_q;

  assign pick_d = ~last_d_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d_q <= 1'b0;
    end else if (gnt_i | gnt_d) begin
      last_d_q <= gnt_d;
    end
  end
`else
  assign pick_d = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else if (clk_en) begin
      state <= state_next;
    end
  end

  // Grants are combinational and only possible in IDLE; mem_done marks the
  // last ACCESS/WAIT cycle, on whose closing edge mem_rdata is captured.
  always_comb begin
    state_next = state;
    gnt_i      = 1'b0;
    gnt_d      = 1'b0;
    mem_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clk_en && rst) begin
          if (d_req && (!i_ok || pick_d)) begin
            gnt_d      = 1'b1;
            state_next = ST_ACCESS;
          end else if (i_ok) begin
            gnt_i      = 1'b1;
            state_next = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (WAIT_STATES == 0) begin
          mem_done   = 1'b1;
          state_next = ST_RESP;
        end else begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt <= 4'd1) begin
          mem_done   = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign sel_addr = gnt_d ? d_addr : i_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      src_d_q <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= '0;
    end else if (clk_en) begin
      if (gnt_i | gnt_d) begin
        addr_q  <= sel_addr;
        we_q    <= gnt_d & d_we;
        wdata_q <= gnt_d ? d_wdata : '0;
        src_d_q <= gnt_d;
        mis_q   <= |(sel_addr & ALIGN_MASK);
      end
      if (state == ST_ACCESS) begin
        cnt <= 4'(WAIT_STATES);
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (mem_done) begin
        rdata_q <= (we_q | mis_q) ? '0 : mem_rdata;
        err_q   <= err_q | {mis_q & src_d_q, mis_q & ~src_d_q};
      end
    end
  end

  // Misaligned accesses still walk the FSM but never touch memory.
  assign strobe    = (state == ST_ACCESS) && !mis_q;
  assign mem_re    = strobe & ~we_q;
  assign mem_we    = strobe & we_q;
  assign mem_addr  = strobe ? addr_q : '0;
  assign mem_wdata = mem_we ? wdata_q : '0;

  assign i_gnt    = gnt_i;
  assign d_gnt    = gnt_d;
  assign i_valid  = (state == ST_RESP) && !src_d_q;
  assign d_valid  = (state == ST_RESP) && src_d_q;
  assign i_rdata  = i_valid ? rdata_q : '0;
  assign d_rdata  = d_valid ? rdata_q : '0;
  assign busy     = (state != ST_IDLE);
  assign err_bits = err_q;

endmodule

// File: tb/tb_scc_mem_arbiter.sv
// tb_scc_mem_arbiter
//   Self-checking bench for scc_mem_arbiter (WAIT_STATES=2). A transaction
//   level reference model predicts grants, strobes, responses and error bits
//   from the arbitration rules and the grant-to-valid latency.
module tb_scc_mem_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned WS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clk_en = 1'b1;
  logic          halt = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_gnt, i_valid;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_valid;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_re, mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy;
  logic [1:0]    err_bits;

  always #5 clk = ~clk;

  scc_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .halt(halt),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .err_bits(err_bits)
  );

  function automatic logic [DW-1:0] init_word(input int unsigned k);
    if (k == 4) return 32'hDEADBEEF;
    return DW'(k * 32'h01010101) ^ 32'hA5A5A5A5;
  endfunction

  // Memory device: data stays on mem_rdata after the strobe until the next one.
  logic [DW-1:0] env_mem [16];
  logic [AW-1:0] env_lat = '0;
  bit            env_ready = 1'b0;
  always @(posedge clk) begin
    if (!env_ready) begin
      for (int k = 0; k < 16; k++) env_mem[k] <= init_word(k);
      env_ready <= 1'b1;
    end else begin
      if (mem_re || mem_we) env_lat <= mem_addr;
      if (mem_we) env_mem[mem_addr[5:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = env_mem[mem_re ? mem_addr[5:2] : env_lat[5:2]];

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [DW-1:0] ref_mem [16];
  int unsigned   en_cyc = 0;
  int unsigned   free_at = 0;
  int unsigned   m_gnt_at = 0;
  bit            m_act = 1'b0;
  bit            m_src_d = 1'b0;
  bit            m_we = 1'b0;
  bit            m_mis = 1'b0;
  bit            m_last_d = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0;
  logic [DW-1:0] m_data = '0;
  logic [1:0]    m_err = '0;
  logic          x_gi = 1'b0;
  logic          x_gd = 1'b0;

  // One clock: compare at negedge, then advance past the next rising edge.
  task automatic step();
    int   ph;
    logic e_busy, e_re, e_we, e_iv, e_dv, wi;
    @(negedge clk);
    if (m_act) ph = int'(en_cyc - m_gnt_at);
    else       ph = -1;
    if (ph > int'(WS) + 2) begin
      m_act = 1'b0;
      ph    = -1;
    end
    e_busy = (ph >= 1);
    e_re   = (ph == 1) && !m_we && !m_mis;
    e_we   = (ph == 1) && m_we && !m_mis;
    e_iv   = (ph == int'(WS) + 2) && !m_src_d;
    e_dv   = (ph == int'(WS) + 2) && m_src_d;
    if (ph == int'(WS) + 2 && m_mis) m_err[m_src_d] = 1'b1;

    x_gi = 1'b0;
    x_gd = 1'b0;
    wi   = i_req && !halt;
    if (clk_en && en_cyc >= free_at) begin
      if (d_req && wi) begin
`ifdef SCC_ARB_RR_EN
        x_gd = !m_last_d;
        x_gi = m_last_d;
`else
        x_gd = 1'b1;
`endif
      end else begin
        x_gd = d_req;
        x_gi = !d_req && wi;
      end
    end

    check("i_gnt",    64'(i_gnt),    64'(x_gi));
    check("d_gnt",    64'(d_gnt),    64'(x_gd));
    check("i_valid",  64'(i_valid),  64'(e_iv));
    check("d_valid",  64'(d_valid),  64'(e_dv));
    check("busy",     64'(busy),     64'(e_busy));
    check("mem_re",   64'(mem_re),   64'(e_re));
    check("mem_we",   64'(mem_we),   64'(e_we));
    check("err_bits", 64'(err_bits), 64'(m_err));
    if (e_re || e_we) check("mem_addr", 64'(mem_addr), 64'(m_addr));
    if (e_we) check("mem_wdata", 64'(mem_wdata), 64'(m_wd));
    if (e_iv) check("i_rdata", 64'(i_rdata), 64'(m_data));
    if (e_dv) check("d_rdata", 64'(d_rdata), 64'(m_data));

    if (x_gi || x_gd) begin
      m_act    = 1'b1;
      m_gnt_at = en_cyc;
      free_at  = en_cyc + WS + 3;
      m_src_d  = x_gd;
      m_last_d = x_gd;
      m_addr   = x_gd ? d_addr : i_addr;
      m_we     = x_gd && d_we;
      m_wd     = d_wdata;
      m_mis    = (m_addr[1:0] != 2'b00);
      if (m_mis) m_data = '0;
      else if (m_we) begin
        ref_mem[m_addr[5:2]] = d_wdata;
        m_data = '0;
      end else m_data = ref_mem[m_addr[5:2]];
    end
    @(posedge clk);
    if (clk_en) en_cyc++;
    #1;
  endtask

  // Step and drop whichever request the model saw granted.
  task automatic cycle();
    step();
    if (x_gd) d_req = 1'b0;
    if (x_gi) i_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_busy",     64'(busy),     64'd0);
    check("rst_gnt",      64'({i_gnt, d_gnt}),     64'd0);
    check("rst_valid",    64'({i_valid, d_valid}), 64'd0);
    check("rst_strobe",   64'({mem_re, mem_we}),   64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_err_bits", 64'(err_bits), 64'd0);
    m_act = 1'b0; free_at = 0; m_err = '0; m_last_d = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 15) * 4);
    if ($urandom_range(0, 7) == 0) a = a + AW'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    for (int k = 0; k < 16; k++) ref_mem[k] = init_word(k);
    @(posedge clk);
    do_reset();

    // single fetch of 0x10
    i_req = 1'b1; i_addr = 32'h10;
    repeat (7) cycle();

    // write 0x12345678 to 0x20, then read it back
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
    repeat (6) cycle();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    repeat (6) cycle();
    check("readback_model", 64'(m_data), 64'h12345678);

    // contention: single round, then sustained
    i_req = 1'b1; i_addr = 32'h04; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h08;
    repeat (12) cycle();
    for (int n = 0; n < 20; n++) begin
      i_req = 1'b1; d_req = 1'b1;
      cycle();
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (6) cycle();

    // misaligned data access
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h22;
    repeat (8) cycle();
    check("err_sticky", 64'(err_bits), 64'b10);

    // halt blocks fetch; release lets it through; halt after grant still completes
    halt = 1'b1; i_req = 1'b1; i_addr = 32'h0C;
    repeat (10) cycle();
    halt = 1'b0;
    cycle();
    halt = 1'b1;
    repeat (6) cycle();
    halt = 1'b0;

    // clk_en low for 3 cycles during WAIT
    i_req = 1'b1; i_addr = 32'h10;
    repeat (3) cycle();
    clk_en = 1'b0;
    repeat (3) cycle();
    clk_en = 1'b1;
    repeat (6) cycle();

    // reset during WAIT
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14;
    repeat (3) cycle();
    do_reset();
    repeat (8) cycle();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cycle();
      if (!d_req && $urandom_range(0, 3) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = rand_addr(); d_wdata = $urandom;
      end
      if (!i_req && $urandom_range(0, 3) == 0) begin
        i_req = 1'b1; i_addr = rand_addr();
      end
      clk_en = ($urandom_range(0, 9) != 0);
      halt   = ($urandom_range(0, 7) == 0);
    end
    clk_en = 1'b1; halt = 1'b0; i_req = 1'b0; d_req = 1'b0;
    repeat (10) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/scc_mem_arbiter.md
Name: scc_mem_arbiter

Overview:
- Parametrised memory front-end for the next-generation SCC.
- Arbitrates the core's instruction-fetch and data-access requesters onto one unified single-port synchronous memory.
- Configurable data/address width and memory wait states; valid/grant handshakes; halt-aware fetch gating; sticky misalignment error reporting.
- Sits between the scc core and the unified memory inside the top level.

Parameters:
- DATA_W, 32, data bus width in bits; power of two, >= 8.
- ADDR_W, 32, byte-address width.
- WAIT_STATES, 0, extra cycles the memory needs after a strobe before mem_rdata is valid; 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- clk_en  in  1  global advance enable; low freezes all state.
- halt  in  1  core halted; blocks new instruction fetches.
- i_req  in  1  fetch request; held until granted.
- i_addr  in  ADDR_W  fetch byte address.
- i_gnt  out  1  fetch accepted this cycle.
- i_valid  out  1  one-cycle fetch response strobe.
- i_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request; held until granted.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  data request accepted this cycle.
- d_valid  out  1  one-cycle data response or write acknowledge.
- d_rdata  out  DATA_W  read data; 0 for writes.
- mem_addr  out  ADDR_W  memory address.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  state != IDLE.
- err_bits  out  2  sticky errors: [0] misaligned fetch, [1] misaligned data access.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; wait counter = 0.
  - All outputs 0, including err_bits.
  - Any in-flight transaction is aborted; no valid pulse follows reset release.
- clk_en=0: no state, counter, or output register changes; i_gnt/d_gnt forced 0.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - The grant (i_gnt or d_gnt) is combinational.
  - It is asserted only in IDLE with clk_en=1, for the selected requester.
  - Fixed priority: data over fetch.
  - i_req is ignored while halt=1.
  - On a granted edge: latch address, we, wdata and source; go to ACCESS.
- ACCESS (one cycle):
  - Drive mem_addr, plus mem_re (read) or mem_we/mem_wdata (write), from the latched registers.
  - Load counter = WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, else RESP.
- WAIT: counter decrements each enabled cycle; at 0, go to RESP.
- Read capture: mem_rdata is registered on the edge leaving the last ACCESS/WAIT cycle.
- RESP (one cycle):
  - Assert i_valid or d_valid matching the latched source, with the captured data (0 for writes).
  - Return to IDLE.
  - A new grant is possible in the cycle after RESP.
- Latency: grant edge to valid = WAIT_STATES+2 enabled cycles. Peak throughput is one transaction per WAIT_STATES+3 cycles.
- Alignment:
  - An address is misaligned if its low log2(DATA_W/8) bits are nonzero.
  - A misaligned request is still granted, but ACCESS issues no memory strobe.
  - RESP returns data 0, and the matching err_bits bit sets.
  - err_bits clear only on reset.
- Halt asserted mid-fetch: the in-flight fetch completes and i_valid still pulses. Pending data requests continue to be served.
- Simultaneous i_req and d_req in IDLE: d granted; i_req must be held.
- Strobes, grants and valids never assert in the same cycle for both channels.

Optional Feature:
- Macro: SCC_ARB_RR_EN.
- Defined:
  - Round-robin arbitration using a 1-bit last-served register, reset to "fetch".
  - On contention, the channel not served last wins.
- Undefined: fixed data-over-fetch priority; the last-served register is not built.
- Ports and timing are identical in both builds.

Test Plan:
- Reset then single fetch: WAIT_STATES=2, i_addr=0x10, mem returns 0xDEADBEEF → i_gnt at cycle 0, mem_re with mem_addr=0x10 at cycle 1, i_valid with i_rdata=0xDEADBEEF at cycle 4.
- Write then read-back: d_we=1, addr 0x20, wdata 0x12345678 → mem_we one cycle, d_valid with d_rdata=0. A read of 0x20 then returns 0x12345678.
- Contention: i_req and d_req high together at IDLE → d_gnt first, i_gnt on the cycle after d_valid.
  - With SCC_ARB_RR_EN, repeated contention alternates d, i, d.
- Misaligned data: d_addr=0x22 → no mem strobe, d_valid with 0, err_bits=2'b10, which stays set until rst=0.
- Halt plus clk_en: halt=1 with i_req held → no i_gnt ever.
  - clk_en=0 for 3 cycles during WAIT → valid is delayed by exactly 3 cycles.
- Reset mid-transaction: rst=0 during WAIT → busy=0 immediately, and no valid pulse after release.
